cordic_iter: RTL and testbench
==============================

Name: cordic_iter

Overview:
- Iterative CORDIC engine. Sits directly downstream of the operand-initialisation stage and consumes its registered x, y, z, select and valid.
- Rotation mode (sel_in[3]=0): computes cos/sin of an angle.
- Vectoring mode (sel_in[3]=1): computes magnitude and atan2 of (x, y).
- One operation in flight at a time. Quadrant folding, 0..90° reduction and gain compensation are done inside this block; results go to the output-formatting stage.

Parameters:
- W, 24, data/angle width; two's complement, 8 fractional bits (Q16.8); angles in units of 1/256 degree.
- ITER, 14, number of micro-rotations; legal range 8..16.
- GW, 2, guard bits added to the internal x/y/z datapath.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand strobe from upstream, single-cycle pulse
- in_ready  out  1  high when state is IDLE
- x_in  in  W  x operand (rotation: 1.0 = 0x000100)
- y_in  in  W  y operand (rotation: 0)
- z_in  in  W  angle operand (vectoring: 0)
- sel_in  in  4  operation select; bit3 = vectoring; bits2:0 passed through
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  downstream accept
- res_a  out  W  rotation: cos; vectoring: magnitude
- res_b  out  W  rotation: sin; vectoring: 0
- res_z  out  W  rotation: original z_in; vectoring: atan2(y,x) in (-180°, 180°]
- sel_out  out  4  sel_in captured at accept
- err_drop  out  1  sticky; in_valid arrived while in_ready=0
- err_range  out  1  sticky; rotation z_in <0 or >=92160 (360°)

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE.
  - out_valid, err_drop, err_range = 0.
  - res_a, res_b, res_z, sel_out = 0.
  - Overrides every other event, including mid-ITER. Any in-flight operation is discarded with no output.
- FSM IDLE -> FOLD -> ITER -> SCALE -> DONE -> IDLE.
- Accept: at the edge where in_valid & in_ready. Operands and sel_in are captured; state goes to FOLD.
- Drop: in_valid while not IDLE sets err_drop. The pulse is ignored and the current operation is unaffected.
- FOLD (1 cycle):
  - Rotation: quadrant q = z div 23040 (compare chain, no divider); r = z - q*23040; x=x_in, y=y_in, z=r.
  - Out-of-range rotation z: set err_range, force q=0, r=0.
  - Vectoring with x_in<0: x=-x_in, y=-y_in, z_off = +46080 if y_in>=0, else -46080. Otherwise z_off=0.
- ITER (exactly ITER cycles; counter i = 0..ITER-1):
  - d = sign(z) in rotation mode; d = -sign(y) in vectoring mode.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i].
  - Arithmetic shifts; internal width W+GW; no saturation needed.
- SCALE (1 cycle): multiply x and y by K = 39797 (Q0.16 of 0.607253), then arithmetic shift right 16 and truncate to W.
  - Rotation quadrant fixup, applied to scaled values c, s:
    - q0: (c, s)
    - q1: (-s, c)
    - q2: (-c, -s)
    - q3: (s, -c)
  - Vectoring: res_a = scaled x; res_z = z_acc + z_off, where z_acc is the negated residual angle sum.
- DONE:
  - Results are registered and out_valid=1.
  - out_valid rises on the (ITER+2)th edge after the accepting edge.
  - Outputs are held stable while out_ready=0.
  - On out_valid & out_ready: out_valid=0 and state goes to IDLE. No same-cycle re-accept; in_ready rises the cycle after.
- Vectoring with x=y=0: res_a=0, res_z=0.
- Accuracy:
  - cos/sin within ±2 LSB of ideal.
  - Angle within ±4 LSB (1/64°).

Decomposition:
- Package cordic_pkg holds:
  - W_DEF, FRAC=8
  - DEG90=23040, DEG180=46080, DEG360=92160
  - K_Q16=39797
  - ATAN table (Q16.8 degrees, entries 0..15): 11520, 6801, 3593, 1824, 916, 458, 229, 115, 57, 29, 14, 7, 4, 2, 1, 0
  - State enum {IDLE, FOLD, ITER, SCALE, DONE}
- One natural sub-module: cordic_quadrant_fold. It is combinational and implements the FOLD-state quadrant and range-reduction logic.

Test Plan:
- Rotation z=0, x=256, y=0 -> res_a=256±2, res_b=0±2, res_z=0; out_valid on edge ITER+2 (16) after accept.
- Rotation z=7680 (30°) -> res_a=222±2, res_b=128±2. z=30720 (120°) -> res_a=-128±2, res_b=222±2. z=57600 (225°) -> res_a=-181±2, res_b=-181±2.
- Vectoring:
  - x=256, y=256 -> res_z=11520±4, res_a=362±2.
  - x=-256, y=0 -> res_z=46080±4, res_a=256±2.
  - x=0, y=-256 -> res_z=-23040±4.
- Backpressure: hold out_ready=0 for 20 cycles; pulse in_valid mid-ITER and again in DONE -> outputs stable, err_drop=1, exactly one result delivered when out_ready=1.
- Rotation z=92160 -> err_range=1, res_a=256±2, res_b=0±2.
- Assert rst at ITER i=5 -> next cycle in_ready=1, out_valid=0, errors cleared. A new operation then completes with correct values.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and arctangent table
// for the iterative CORDIC engine.
package cordic_pkg;

  localparam int W_DEF  = 24;
  localparam int FRAC   = 8;
  // Extra low-order bits carried through the micro-rotations
  // so shift truncation does not swamp the 8-bit fraction.
  localparam int FG     = 8;

  localparam int DEG90  = 23040;
  localparam int DEG180 = 46080;
  localparam int DEG270 = 69120;
  localparam int DEG360 = 92160;

  localparam int K_Q16  = 39797;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FOLD,
    S_ITER,
    S_SCALE,
    S_DONE
  } state_t;

  // atan(2^-i) in 1/256 degree
  function automatic logic [13:0] atan_lut(
    input logic [3:0] idx
  );
    case (idx)
      4'd0:    atan_lut = 14'd11520;
      4'd1:    atan_lut = 14'd6801;
      4'd2:    atan_lut = 14'd3593;
      4'd3:    atan_lut = 14'd1824;
      4'd4:    atan_lut = 14'd916;
      4'd5:    atan_lut = 14'd458;
      4'd6:    atan_lut = 14'd229;
      4'd7:    atan_lut = 14'd115;
      4'd8:    atan_lut = 14'd57;
      4'd9:    atan_lut = 14'd29;
      4'd10:   atan_lut = 14'd14;
      4'd11:   atan_lut = 14'd7;
      4'd12:   atan_lut = 14'd4;
      4'd13:   atan_lut = 14'd2;
      4'd14:   atan_lut = 14'd1;
      default: atan_lut = 14'd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Operand folding: quadrant / range reduction for rotation,
// half-plane mirroring for vectoring.
module cordic_quadrant_fold
  import cordic_pkg::*;
#(
  parameter int W  = 24,
  parameter int GW = 2,
  parameter int IW = W + GW + FG
) (
  input  logic                 vec,
  input  logic signed [W-1:0]  x_in,
  input  logic signed [W-1:0]  y_in,
  input  logic signed [W-1:0]  z_in,
  output logic signed [IW-1:0] x0,
  output logic signed [IW-1:0] y0,
  output logic signed [IW-1:0] z0,
  output logic signed [IW-1:0] z_off,
  output logic [1:0]           q,
  output logic                 range_err,
  output logic                 zero_vec
);

  localparam logic signed [W-1:0] D90  = W'(DEG90);
  localparam logic signed [W-1:0] D180 = W'(DEG180);
  localparam logic signed [W-1:0] D270 = W'(DEG270);
  localparam logic signed [W-1:0] D360 = W'(DEG360);

  localparam logic signed [IW-1:0] OFF180 = IW'(DEG180);

  logic signed [IW-1:0] xe;
  logic signed [IW-1:0] ye;
  logic signed [W-1:0]  r;

  // headroom on top, fractional guard below
  assign xe = {{GW{x_in[W-1]}}, x_in, {FG{1'b0}}};
  assign ye = {{GW{y_in[W-1]}}, y_in, {FG{1'b0}}};

  // fold the operands into the CORDIC convergence range
  always_comb begin
    x0        = xe;
    y0        = ye;
    z0        = '0;
    z_off     = '0;
    q         = 2'd0;
    range_err = 1'b0;
    zero_vec  = 1'b0;
    r         = '0;
    if (vec) begin
      zero_vec = (x_in == '0) && (y_in == '0);
      if (x_in[W-1]) begin
        x0    = -xe;
        y0    = -ye;
        z_off = y_in[W-1] ? -OFF180 : OFF180;
      end
    end else begin
      if (z_in[W-1] || z_in >= D360) begin
        range_err = 1'b1;
      end else if (z_in >= D270) begin
        q = 2'd3;
        r = z_in - D270;
      end else if (z_in >= D180) begin
        q = 2'd2;
        r = z_in - D180;
      end else if (z_in >= D90) begin
        q = 2'd1;
        r = z_in - D90;
      end else begin
        r = z_in;
      end
      z0 = {{(IW-W){r[W-1]}}, r};
    end
  end

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: rotation (cos/sin) and
// vectoring (magnitude/atan2), one operation in flight.
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int ITER = 14,
  parameter int GW   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] z_in,
  input  logic [3:0]   sel_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res_a,
  output logic [W-1:0] res_b,
  output logic [W-1:0] res_z,
  output logic [3:0]   sel_out,
  output logic         err_drop,
  output logic         err_range
);

  localparam int IW = W + GW + FG;
  localparam int CW = $clog2(ITER) + 1;
  localparam int PW = IW + 18;

  localparam logic signed [17:0] KS = 18'(K_Q16);

  state_t state;

  logic signed [W-1:0]  xa;
  logic signed [W-1:0]  ya;
  logic signed [W-1:0]  za;
  logic [3:0]           sel_r;
  logic                 vec_r;

  logic signed [IW-1:0] xr;
  logic signed [IW-1:0] yr;
  logic signed [IW-1:0] zr;
  logic signed [IW-1:0] zoff_r;
  logic [1:0]           q_r;
  logic                 zero_r;
  logic [CW-1:0]        i_r;

  logic signed [IW-1:0] fx;
  logic signed [IW-1:0] fy;
  logic signed [IW-1:0] fz;
  logic signed [IW-1:0] foff;
  logic [1:0]           fq;
  logic                 frange;
  logic                 fzero;

  logic signed [IW-1:0] xs;
  logic signed [IW-1:0] ys;
  logic signed [IW-1:0] at;
  logic signed [IW-1:0] x_n;
  logic signed [IW-1:0] y_n;
  logic signed [IW-1:0] z_n;
  logic                 d_pos;

  logic signed [PW-1:0] xw;
  logic signed [PW-1:0] yw;
  logic signed [PW-1:0] px;
  logic signed [PW-1:0] py;
  logic signed [W-1:0]  c;
  logic signed [W-1:0]  s;
  logic signed [W-1:0]  ra;
  logic signed [W-1:0]  rb;
  logic signed [W-1:0]  rz;

  assign in_ready = (state == S_IDLE);

  cordic_quadrant_fold #(
    .W  (W),
    .GW (GW),
    .IW (IW)
  ) u_fold (
    .vec       (vec_r),
    .x_in      (xa),
    .y_in      (ya),
    .z_in      (za),
    .x0        (fx),
    .y0        (fy),
    .z0        (fz),
    .z_off     (foff),
    .q         (fq),
    .range_err (frange),
    .zero_vec  (fzero)
  );

  // one micro-rotation step
  always_comb begin
    d_pos = vec_r ? yr[IW-1] : ~zr[IW-1];
    xs    = xr >>> i_r;
    ys    = yr >>> i_r;
    at    = {{(IW-14){1'b0}}, atan_lut(i_r[3:0])};
    if (d_pos) begin
      x_n = xr - ys;
      y_n = yr + xs;
      z_n = zr - at;
    end else begin
      x_n = xr + ys;
      y_n = yr - xs;
      z_n = zr + at;
    end
  end

  // gain compensation, quadrant fixup, result select
  always_comb begin
    xw = PW'(xr);
    yw = PW'(yr);
    px = xw * PW'(KS);
    py = yw * PW'(KS);
    c  = W'(px >>> (16 + FG));
    s  = W'(py >>> (16 + FG));
    ra = c;
    rb = s;
    rz = za;
    if (vec_r) begin
      rb = '0;
      rz = zero_r ? '0 : W'(zr + zoff_r);
    end else begin
      unique case (q_r)
        2'd0: begin ra = c;  rb = s;  end
        2'd1: begin ra = -s; rb = c;  end
        2'd2: begin ra = -c; rb = -s; end
        2'd3: begin ra = s;  rb = -c; end
      endcase
    end
  end

  // sequencing FSM with registered datapath and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      err_drop  <= 1'b0;
      err_range <= 1'b0;
      res_a     <= '0;
      res_b     <= '0;
      res_z     <= '0;
      sel_out   <= '0;
      xa        <= '0;
      ya        <= '0;
      za        <= '0;
      sel_r     <= '0;
      vec_r     <= 1'b0;
      xr        <= '0;
      yr        <= '0;
      zr        <= '0;
      zoff_r    <= '0;
      q_r       <= '0;
      zero_r    <= 1'b0;
      i_r       <= '0;
    end else begin
      if (in_valid && state != S_IDLE)
        err_drop <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            xa    <= x_in;
            ya    <= y_in;
            za    <= z_in;
            sel_r <= sel_in;
            vec_r <= sel_in[3];
            state <= S_FOLD;
          end
        end
        S_FOLD: begin
          xr     <= fx;
          yr     <= fy;
          zr     <= fz;
          zoff_r <= foff;
          q_r    <= fq;
          zero_r <= fzero;
          i_r    <= '0;
          if (frange)
            err_range <= 1'b1;
          state  <= S_ITER;
        end
        S_ITER: begin
          xr  <= x_n;
          yr  <= y_n;
          zr  <= z_n;
          i_r <= i_r + 1'b1;
          if (i_r == CW'(ITER - 1))
            state <= S_SCALE;
        end
        S_SCALE: begin
          res_a     <= ra;
          res_b     <= rb;
          res_z     <= rz;
          sel_out   <= sel_r;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter: vector table plus
// backpressure, range-error and mid-run reset sequences.
module tb_cordic_iter;

  localparam int W    = 24;
  localparam int ITER = 14;
  localparam int GW   = 2;
  localparam int TMO  = 60;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic signed [W-1:0] z_in;
  logic [3:0]         sel_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [W-1:0] res_a;
  logic signed [W-1:0] res_b;
  logic signed [W-1:0] res_z;
  logic [3:0]         sel_out;
  logic               err_drop;
  logic               err_range;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         x;
    int         y;
    int         z;
    logic [3:0] sel;
    int         ea;
    int         eb;
    int         ez;
    int         ta;
    int         tz;
  } vec_t;

  vec_t tv[9];
  vec_t rv;

  cordic_iter #(
    .W    (W),
    .ITER (ITER),
    .GW   (GW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .sel_in    (sel_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_a     (res_a),
    .res_b     (res_b),
    .res_z     (res_z),
    .sel_out   (sel_out),
    .err_drop  (err_drop),
    .err_range (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act,
                     input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d +/- %0d",
               name, act, exp, tol);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    x_in     = W'(v.x);
    y_in     = W'(v.y);
    z_in     = W'(v.z);
    sel_in   = v.sel;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    int n;
    chk({tag, ".ready"}, int'(in_ready), 1, 0);
    drive(v);
    wait_valid(n);
    chk({tag, ".lat"}, n, ITER + 2, 0);
    chk({tag, ".a"}, int'(res_a), v.ea, v.ta);
    chk({tag, ".b"}, int'(res_b), v.eb, v.ta);
    chk({tag, ".z"}, int'(res_z), v.ez, v.tz);
    chk({tag, ".sel"}, int'(sel_out), int'(v.sel), 0);
    take();
    chk({tag, ".ack"}, int'(out_valid), 0, 0);
  endtask

  initial begin
    int n;
    int cnt;
    int stable;
    int sa, sb, sz;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;
    sel_in    = '0;

    tv[0] = '{x:256, y:0, z:0, sel:4'h1,
              ea:256, eb:0, ez:0, ta:2, tz:0};
    tv[1] = '{x:256, y:0, z:7680, sel:4'h2,
              ea:222, eb:128, ez:7680, ta:2, tz:0};
    tv[2] = '{x:256, y:0, z:30720, sel:4'h3,
              ea:-128, eb:222, ez:30720, ta:2, tz:0};
    tv[3] = '{x:256, y:0, z:57600, sel:4'h4,
              ea:-181, eb:-181, ez:57600, ta:2, tz:0};
    tv[4] = '{x:0, y:0, z:23040, sel:4'h6,
              ea:0, eb:256, ez:23040, ta:2, tz:0};
    tv[5] = '{x:256, y:256, z:0, sel:4'hD,
              ea:362, eb:0, ez:11520, ta:2, tz:4};
    tv[6] = '{x:-256, y:0, z:0, sel:4'hE,
              ea:256, eb:0, ez:46080, ta:2, tz:4};
    tv[7] = '{x:0, y:-256, z:0, sel:4'hF,
              ea:256, eb:0, ez:-23040, ta:2, tz:4};
    tv[8] = '{x:0, y:0, z:0, sel:4'h8,
              ea:0, eb:0, ez:0, ta:0, tz:0};
    // rotation operands for the 90-degree case
    tv[4].x = 256;

    rv = '{x:256, y:0, z:92160, sel:4'h5,
           ea:256, eb:0, ez:92160, ta:2, tz:0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", int'(in_ready), 1, 0);
    chk("rst.out_valid", int'(out_valid), 0, 0);
    chk("rst.res_a", int'(res_a), 0, 0);
    chk("rst.err_drop", int'(err_drop), 0, 0);
    chk("rst.err_range", int'(err_range), 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 9; k++)
      apply(tv[k], $sformatf("v%0d", k));

    chk("tbl.err_drop", int'(err_drop), 0, 0);
    chk("tbl.err_range", int'(err_range), 0, 0);

    // backpressure with dropped pulses mid-ITER and in DONE
    drive(tv[1]);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    x_in     = W'(100);
    z_in     = W'(0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp.err_drop", int'(err_drop), 1, 0);
    wait_valid(n);
    chk("bp.lat", n, ITER + 2 - 6, 0);
    sa = int'(res_a);
    sb = int'(res_b);
    sz = int'(res_z);
    chk("bp.a", sa, 222, 2);
    chk("bp.b", sb, 128, 2);
    chk("bp.z", sz, 7680, 0);
    stable = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin
        @(negedge clk);
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (!out_valid || int'(res_a) != sa ||
          int'(res_b) != sb || int'(res_z) != sz)
        stable = 0;
    end
    chk("bp.stable", stable, 1, 0);
    chk("bp.in_ready_busy", int'(in_ready), 0, 0);
    take();
    chk("bp.ack", int'(out_valid), 0, 0);
    chk("bp.in_ready", int'(in_ready), 1, 0);
    cnt = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    chk("bp.extra", cnt, 0, 0);

    // out-of-range rotation angle
    apply(rv, "range");
    chk("range.err", int'(err_range), 1, 0);

    // reset while iterating
    drive(tv[2]);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst.in_ready", int'(in_ready), 1, 0);
    chk("mrst.out_valid", int'(out_valid), 0, 0);
    chk("mrst.err_drop", int'(err_drop), 0, 0);
    chk("mrst.err_range", int'(err_range), 0, 0);
    chk("mrst.res_a", int'(res_a), 0, 0);
    chk("mrst.sel_out", int'(sel_out), 0, 0);
    cnt = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    chk("mrst.no_out", cnt, 0, 0);
    apply(tv[1], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
